vga_v_sync: RTL and testbench



---
 rtl/vga_v_sync.sv | 137 +++++++++++++
 tb/tb_vga_v_sync.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_v_sync.sv
// Vertical VGA timing: line counter, sync pulses, visible flag, pixel coordinates, frame strobe.
// Define VGA_FRAME_CNT_EN to add the 8-bit frame_cnt output.
module vga_v_sync #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_TOTAL   = 525
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] h_count,
    input  logic       trig_v,
    output logic [9:0] v_count,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       frame_tick,
`ifdef VGA_FRAME_CNT_EN
    output logic [7:0] frame_cnt,
`endif
    output logic [2:0] v_state
);

    localparam logic [9:0] H_VIS_END = 10'(H_VISIBLE);
    localparam logic [9:0] HS_START  = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END    = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VF_START  = 10'(V_VISIBLE);
    localparam logic [9:0] VS_START  = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VB_START  = 10'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);

    typedef enum logic [2:0] {
        ST_V_WAIT   = 3'd0,
        ST_V_ACTIVE = 3'd1,
        ST_V_FRONT  = 3'd2,
        ST_V_SYNC   = 3'd3,
        ST_V_BACK   = 3'd4
    } v_state_e;

    v_state_e   state_q, state_d;
    logic [9:0] line_q, line_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       video_on_q, video_on_d;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       tick_q, tick_d;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0] fcnt_q, fcnt_d;
`endif

    always_comb begin
        state_d    = state_q;
        line_d     = line_q;
        tick_d     = 1'b0;
        hsync_d    = 1'b1;
        vsync_d    = 1'b1;
        video_on_d = 1'b0;
        x_d        = 10'd0;
        y_d        = 10'd0;
`ifdef VGA_FRAME_CNT_EN
        fcnt_d     = fcnt_q;
`endif
        if (trig_v) begin
            // The first strobe after reset only locks onto line 0; it is not a frame wrap.
            if (state_q == ST_V_WAIT) begin
                line_d = 10'd0;
            end else if (line_q >= V_LAST) begin
                line_d = 10'd0;
                tick_d = 1'b1;
            end else begin
                line_d = line_q + 10'd1;
            end
            if (line_d < VF_START)      state_d = ST_V_ACTIVE;
            else if (line_d < VS_START) state_d = ST_V_FRONT;
            else if (line_d < VB_START) state_d = ST_V_SYNC;
            else                        state_d = ST_V_BACK;
        end
        // Outputs follow the post-update line so h=0 already shows the new line.
        if (state_d != ST_V_WAIT) begin
            hsync_d    = !((h_count >= HS_START) && (h_count < HS_END));
            vsync_d    = (state_d != ST_V_SYNC);
            video_on_d = (h_count < H_VIS_END) && (state_d == ST_V_ACTIVE);
            x_d        = video_on_d ? h_count : 10'd0;
            y_d        = video_on_d ? line_d  : 10'd0;
        end
`ifdef VGA_FRAME_CNT_EN
        if (tick_d) fcnt_d = fcnt_q + 8'd1;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_V_WAIT;
            line_q     <= 10'd0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            video_on_q <= 1'b0;
            x_q        <= 10'd0;
            y_q        <= 10'd0;
            tick_q     <= 1'b0;
`ifdef VGA_FRAME_CNT_EN
            fcnt_q     <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            line_q     <= line_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            video_on_q <= video_on_d;
            x_q        <= x_d;
            y_q        <= y_d;
            tick_q     <= tick_d;
`ifdef VGA_FRAME_CNT_EN
            fcnt_q     <= fcnt_d;
`endif
        end
    end

    assign v_count    = line_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign video_on   = video_on_q;
    assign x          = x_q;
    assign y          = y_q;
    assign frame_tick = tick_q;
    assign v_state    = state_q;
`ifdef VGA_FRAME_CNT_EN
    assign frame_cnt  = fcnt_q;
`endif

endmodule

// File: tb/tb_vga_v_sync.sv
// Bench for vga_v_sync with shrunk timing (96-pixel lines, 32-line frames) and a line-number model.
module tb_vga_v_sync;
  localparam int HV = 64, HFP = 4, HSW = 8;
  localparam int VV = 24, VFP = 3, VSW = 2, VT = 32;
  localparam int LINE_LEN = 96;
  localparam int HS0 = HV + HFP, HS1 = HV + HFP + HSW;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] h_count;
  logic       trig_v;
  logic [9:0] v_count, x, y;
  logic       hsync, vsync, video_on, frame_tick;
  logic [2:0] v_state;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0] frame_cnt;
`endif

  vga_v_sync #(
    .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HSW),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSW), .V_TOTAL(VT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .h_count(h_count), .trig_v(trig_v),
    .v_count(v_count), .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .x(x), .y(y), .frame_tick(frame_tick),
`ifdef VGA_FRAME_CNT_EN
    .frame_cnt(frame_cnt),
`endif
    .v_state(v_state)
  );

  // clock
  always #20 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // model: tracks lock and line number, derives outputs from line ranges
  bit locked;
  int mline, mfc;
  int e_v, e_x, e_y;
  bit e_hs, e_vs, e_von, e_tick;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked = 0; mline = 0; mfc = 0;
      e_v = 0; e_x = 0; e_y = 0; e_hs = 1; e_vs = 1; e_von = 0; e_tick = 0;
    end else begin
      int h;
      h = int'(h_count);
      e_tick = 0;
      if (trig_v) begin
        if (!locked) begin
          locked = 1; mline = 0;
        end else if (mline == VT - 1) begin
          mline = 0; e_tick = 1; mfc = (mfc + 1) % 256;
        end else begin
          mline = mline + 1;
        end
      end
      if (locked) begin
        e_hs  = !(h >= HS0 && h < HS1);
        e_vs  = !(mline >= VV + VFP && mline < VV + VFP + VSW);
        e_von = (h < HV) && (mline < VV);
        e_x   = e_von ? h : 0;
        e_y   = e_von ? mline : 0;
        e_v   = mline;
      end
    end
  end

  // per-cycle compare plus tick/vsync bookkeeping
  int cyc = 0, tick_cnt = 0, last_tick_cyc = 0, tick_gap = 0, last_tick_v = -1, vs_low_cnt = 0;
  always @(negedge clk) begin
    cyc++;
    if (cmp_en) begin
      chk("v_count", int'(v_count), e_v);
      chk("hsync", int'(hsync), int'(e_hs));
      chk("vsync", int'(vsync), int'(e_vs));
      chk("video_on", int'(video_on), int'(e_von));
      chk("x", int'(x), e_x);
      chk("y", int'(y), e_y);
      chk("frame_tick", int'(frame_tick), int'(e_tick));
`ifdef VGA_FRAME_CNT_EN
      chk("frame_cnt", int'(frame_cnt), mfc);
`endif
      if (frame_tick) begin
        tick_cnt++;
        tick_gap = cyc - last_tick_cyc;
        last_tick_cyc = cyc;
        last_tick_v = int'(v_count);
      end
      if (!vsync) vs_low_cnt++;
    end
  end

  // driver tasks
  task automatic drive(input int h, input bit t);
    @(negedge clk);
    h_count = 10'(h);
    trig_v  = t;
  endtask

  task automatic drive_line(input int n);
    for (int l = 0; l < n; l++)
      for (int h = 0; h < LINE_LEN; h++) drive(h, h == 0);
  endtask

  initial begin
    rst_n = 1'b0; h_count = 10'd0; trig_v = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_v_count", int'(v_count), 0);
    chk("rst_hsync", int'(hsync), 1);
    chk("rst_vsync", int'(vsync), 1);
    chk("rst_video_on", int'(video_on), 0);
    chk("rst_x", int'(x), 0);
    chk("rst_y", int'(y), 0);
    chk("rst_frame_tick", int'(frame_tick), 0);
    cmp_en = 1;
    rst_n = 1'b1;

    // unlocked: h in the sync range must not move hsync
    for (int h = 60; h < 80; h++) begin
      drive(h, 0);
      if (h == 75) chk("wait_hsync", int'(hsync), 1);
    end

    // lock line
    for (int h = 0; h < LINE_LEN; h++) begin
      drive(h, h == 0);
      if (h == 1) begin
        chk("lock_v_count", int'(v_count), 0);
        chk("lock_video_on", int'(video_on), 1);
        chk("lock_no_tick", int'(frame_tick), 0);
      end
      if (h == 11) chk("lock_x_delay", int'(x), 10);
      if (h == 66) chk("h65_video_off", int'(video_on), 0);
      if (h == 70) chk("h69_hsync_low", int'(hsync), 0);
    end
    chk("no_tick_on_lock", tick_cnt, 0);

    // two full frames
    vs_low_cnt = 0;
    drive_line(64);
    chk("tick_count_2frames", tick_cnt, 2);
    chk("tick_gap", tick_gap, VT * LINE_LEN);
    chk("vsync_low_cycles", vs_low_cnt, 2 * VSW * LINE_LEN);

    // spurious strobe mid-line 10
    drive_line(9);
    for (int h = 0; h < LINE_LEN; h++) begin
      drive(h, h == 0 || h == 40);
      if (h == 41) chk("spur_v_count", int'(v_count), 11);
    end
    drive_line(20);
    chk("spur_no_early_tick", tick_cnt, 2);
    drive_line(1);
    chk("spur_wrap_tick", tick_cnt, 3);
    chk("spur_wrap_v0", last_tick_v, 0);

    // out-of-range h on visible line 1
    for (int h = 0; h < LINE_LEN; h++) begin
      if (h == 50) drive(900, 0);
      else if (h == 51) drive(1023, 0);
      else drive(h, h == 0);
      if (h == 51) begin
        chk("h900_video_on", int'(video_on), 0);
        chk("h900_hsync", int'(hsync), 1);
      end
      if (h == 52) chk("h1023_x", int'(x), 0);
    end

    // asynchronous reset at line 20, h=40
    drive_line(18);
    for (int h = 0; h <= 40; h++) drive(h, h == 0);
    @(posedge clk);
    #2;
    chk("pre_rst_v_count", int'(v_count), 20);
    chk("pre_rst_x", int'(x), 40);
    rst_n = 1'b0;
    #1;
    chk("arst_v_count", int'(v_count), 0);
    chk("arst_x", int'(x), 0);
    chk("arst_y", int'(y), 0);
    chk("arst_video_on", int'(video_on), 0);
    chk("arst_hsync", int'(hsync), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int h = 70; h < 74; h++) drive(h, 0);
    chk("relock_wait_hsync", int'(hsync), 1);
    for (int h = 0; h < LINE_LEN; h++) begin
      drive(h, h == 0);
      if (h == 1) begin
        chk("relock_v_count", int'(v_count), 0);
        chk("relock_video_on", int'(video_on), 1);
        chk("relock_no_tick", int'(frame_tick), 0);
      end
    end

`ifdef VGA_FRAME_CNT_EN
    // strobe every cycle: one frame per VT cycles
    for (int i = 1; i <= 257 * VT; i++) drive(i % LINE_LEN, 1);
    drive(0, 0);
    drive(0, 0);
    chk("frame_cnt_257", int'(frame_cnt), 1);
`endif

    drive(0, 0);
    drive(0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
